// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS core's Avalon-MM load/store path.
package mips_bus_pkg;

  typedef enum logic [3:0] {
    OP_FETCH = 4'd0,
    OP_LB    = 4'd1,
    OP_LBU   = 4'd2,
    OP_LH    = 4'd3,
    OP_LHU   = 4'd4,
    OP_LW    = 4'd5,
    OP_LWL   = 4'd6,
    OP_LWR   = 4'd7,
    OP_SB    = 4'd8,
    OP_SH    = 4'd9,
    OP_SW    = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  // Byte offset within the word -> physical byte lane on the bus.
  function automatic logic [1:0] lane_sel(input logic [1:0] ofs, input bit little_endian);
    return little_endian ? ofs : 2'd3 - ofs;
  endfunction

  function automatic logic op_legal(input lsu_op_t op);
    return op <= OP_SW;
  endfunction

  function automatic logic op_is_store(input lsu_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input lsu_op_t op, input logic [1:0] ofs);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH:  bad = ofs[0];
      OP_FETCH, OP_LW, OP_SW: bad = (ofs != 2'd0);
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_if.sv
// Avalon-MM bus between the load/store unit (master) and memory (slave).
interface mips_cpu_lsu_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_lane_align.sv
// Combinational byte-lane steering: byteenable, replicated store data and formatted load result.
module mips_bus_lane_align
  import mips_bus_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  lsu_op_t     op,
  input  logic [1:0]  ofs,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  input  logic [31:0] rt_old,
  output logic [3:0]  be,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data
);

  logic [1:0]          bl;
  logic                hl;
  logic [1:0]          mo;
  logic [4:0]          sh;
  logic signed [7:0]   byte_s;
  logic signed [15:0]  half_s;

  always_comb begin
    be      = 4'b0000;
    wr_data = 32'd0;
    ld_data = 32'd0;
    sh      = 5'd0;
    bl      = lane_sel(ofs, LITTLE_ENDIAN);
    hl      = LITTLE_ENDIAN ? ofs[1] : ~ofs[1];
    // Unaligned-word merges count offsets from the other end on a big-endian bus.
    mo      = LITTLE_ENDIAN ? ofs : 2'd3 - ofs;
    byte_s  = rd_data[8*bl +: 8];
    half_s  = rd_data[16*hl +: 16];

    case (op)
      OP_FETCH, OP_LW: begin
        be      = 4'b1111;
        ld_data = rd_data;
      end
      OP_LB, OP_LBU: begin
        be      = 4'b0001 << bl;
        ld_data = (op == OP_LB) ? 32'(byte_s) : {24'd0, byte_s};
      end
      OP_LH, OP_LHU: begin
        be      = hl ? 4'b1100 : 4'b0011;
        ld_data = (op == OP_LH) ? 32'(half_s) : {16'd0, half_s};
      end
      OP_LWL: begin
        be      = 4'((5'd2 << mo) - 5'd1);
        sh      = {2'd3 - mo, 3'b000};
        ld_data = (rd_data << sh) | (rt_old & ((32'd1 << sh) - 32'd1));
      end
      OP_LWR: begin
        be      = 4'(4'hF << mo);
        sh      = {mo, 3'b000};
        ld_data = (rd_data >> sh) | (rt_old & ~(32'hFFFF_FFFF >> sh));
      end
      OP_SB: begin
        be      = 4'b0001 << bl;
        wr_data = {4{st_data[7:0]}};
      end
      OP_SH: begin
        be      = hl ? 4'b1100 : 4'b0011;
        wr_data = {2{st_data[15:0]}};
      end
      OP_SW: begin
        be      = 4'b1111;
        wr_data = st_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: single-outstanding Avalon-MM master for the multicycle MIPS core.
module mips_cpu_lsu
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter bit ALIGN_CHECK   = 1'b1,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  mips_cpu_lsu_if.master    bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t        state, state_n;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rt_old_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              err_q;
  logic              accept, req_bad, timed_out, is_store_q, in_bus;
  logic [3:0]        be;
  logic [31:0]       wr_data, ld_data;

  assign accept     = req_valid && req_ready;
  assign req_bad    = !op_legal(req_op) || (ALIGN_CHECK && op_misaligned(req_op, req_addr[1:0]));
  assign timed_out  = (TIMEOUT != 0) && bus.waitrequest && ((int'(tmo_cnt) + 1) >= TIMEOUT);
  assign is_store_q = op_is_store(op_q);
  assign in_bus     = (state == ST_BUS);

  mips_bus_lane_align #(.LITTLE_ENDIAN(LITTLE_ENDIAN)) u_align (
    .op      (op_q),
    .ofs     (addr_q[1:0]),
    .st_data (wdata_q),
    .rd_data (bus.readdata),
    .rt_old  (rt_old_q),
    .be      (be),
    .wr_data (wr_data),
    .ld_data (ld_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = req_bad ? ST_RESP : ST_BUS;
      ST_BUS:  if (!bus.waitrequest || timed_out) state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Control and externally visible state: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      resp_rdata <= 32'd0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (accept) begin
          addr_q     <= req_addr;
          tmo_cnt    <= '0;
          err_q      <= req_bad;
          resp_rdata <= 32'd0;
        end
        ST_BUS: begin
          if (!bus.waitrequest) begin
            err_q      <= 1'b0;
            resp_rdata <= is_store_q ? 32'd0 : ld_data;
          end else if (timed_out) begin
            err_q      <= 1'b1;
            resp_rdata <= 32'd0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request payload: only observed while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= req_op;
      wdata_q  <= req_wdata;
      rt_old_q <= req_rt_old;
    end
  end

  assign req_ready      = (state == ST_IDLE) && !rst;
  assign resp_valid     = (state == ST_RESP);
  assign resp_err       = resp_valid && err_q;
  assign bus.address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.read       = in_bus && !is_store_q;
  assign bus.write      = in_bus && is_store_q;
  assign bus.byteenable = in_bus ? be : 4'b0000;
  assign bus.writedata  = in_bus ? wr_data : 32'd0;

endmodule
